// File: rtl/seq_priority_encoder_pkg.sv
// Shared types and helpers for the serial priority encoder: state encoding,
// a constant-foldable clog2, and a popcount used for both ones_cnt and out_last.
package seq_priority_encoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Widest vector the block supports; popcount is sized to hold this many ones.
  localparam int MAX_N = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [6:0] popcount(input logic [MAX_N-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAX_N; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/seq_priority_encoder_ffs_lsb.sv
// Combinational find-first-set: reports the lowest set bit of vec.
// idx is 0 when no bit is set; qualify it with any.
module ffs_lsb
  import seq_priority_encoder_pkg::*;
#(
  parameter int N = 8,
  localparam int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/seq_priority_encoder.sv
// Serial priority encoder: accepts a one-or-more-hot vector and emits the
// binary index of every set bit, lowest first, over a valid/ready stream.
module seq_priority_encoder
  import seq_priority_encoder_pkg::*;
#(
  parameter int N = 8,
  localparam int IDX_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [IDX_W:0]   ones_cnt,
  output logic             err_zero
);

  state_t           state;
  logic [N-1:0]     pending;
  logic [IDX_W-1:0] low_idx;
  logic             low_any;
  logic [6:0]       pend_cnt;

  ffs_lsb #(.N(N)) u_ffs (
    .vec (pending),
    .idx (low_idx),
    .any (low_any)
  );

  assign pend_cnt = popcount(MAX_N'(pending));

  // in_ready is gated by rst directly so it reads low for the whole reset window.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == SERVE);
  assign out_idx   = low_idx;
  assign out_last  = (state == SERVE) && (pend_cnt == 7'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      ones_cnt <= '0;
      err_zero <= 1'b0;
    end else begin
      err_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (|in_vec) begin
              pending  <= in_vec;
              ones_cnt <= (IDX_W + 1)'(popcount(MAX_N'(in_vec)));
              state    <= SERVE;
            end else begin
              err_zero <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (out_ready && low_any) begin
            pending <= pending & ~({{(N - 1){1'b0}}, 1'b1} << low_idx);
            if (out_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
